// File: rtl/bitmap_scan_encoder_if.sv
// Load/index handshake bundle for bitmap_scan_encoder.
// BITMAP_SCAN_COUNT_EN adds the `remaining` popcount signal.
interface bitmap_scan_encoder_if #(
  parameter int unsigned WIDTH = 64
);
  localparam int unsigned IDX_W = $clog2(WIDTH);

  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] load_vec;
  logic             idx_valid;
  logic             idx_ready;
  logic [IDX_W-1:0] idx_out;
  logic             idx_last;
  logic             flush;
  logic             busy;
  logic             done;

`ifdef BITMAP_SCAN_COUNT_EN
  logic [IDX_W:0]   remaining;

  modport master (
    output load_valid, load_vec, idx_ready, flush,
    input  load_ready, idx_valid, idx_out, idx_last, busy, done, remaining
  );

  modport slave (
    input  load_valid, load_vec, idx_ready, flush,
    output load_ready, idx_valid, idx_out, idx_last, busy, done, remaining
  );
`else
  modport master (
    output load_valid, load_vec, idx_ready, flush,
    input  load_ready, idx_valid, idx_out, idx_last, busy, done
  );

  modport slave (
    input  load_valid, load_vec, idx_ready, flush,
    output load_ready, idx_valid, idx_out, idx_last, busy, done
  );
`endif
endinterface

// File: rtl/bitmap_scan_encoder.sv
// Sequential priority encoder: emits every set bit index of a loaded bitmap, lowest first.
// Optional BITMAP_SCAN_COUNT_EN keeps a registered popcount in `remaining`.
module bitmap_scan_encoder #(
  parameter int unsigned WIDTH = 64
) (
  input logic                  clk,
  input logic                  rst_n,
  bitmap_scan_encoder_if.slave bus
);
  localparam int unsigned IDX_W = $clog2(WIDTH);
  localparam int unsigned CNT_W = IDX_W + 1;

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StScan = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] pending_q, pending_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] lowest;
  logic [IDX_W-1:0] idx;
  logic             scan, last, load_ready, hs;

  assign scan       = (state_q == StScan);
  assign load_ready = !scan && !bus.flush;
  assign hs         = scan && bus.idx_ready;

  // Isolate the lowest set bit, then collapse the one-hot vector with an OR tree.
  assign lowest = pending_q & (-pending_q);

  always_comb begin
    idx = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (lowest[i]) idx = idx | IDX_W'(i);
    end
  end

`ifdef BITMAP_SCAN_COUNT_EN
  logic [CNT_W-1:0] remaining_q, remaining_d, load_cnt;

  always_comb begin
    load_cnt = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      load_cnt = load_cnt + CNT_W'(bus.load_vec[i]);
    end
  end

  assign last          = (remaining_q == CNT_W'(1));
  assign bus.remaining = remaining_q;
`else
  // Exactly one bit set: the isolated lowest bit is the whole (non-empty) pending vector.
  assign last = (pending_q == lowest) && (|pending_q);
`endif

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    done_d    = 1'b0;
`ifdef BITMAP_SCAN_COUNT_EN
    remaining_d = remaining_q;
`endif
    if (!scan) begin
      if (bus.load_valid && load_ready) begin
        if (|bus.load_vec) begin
          pending_d = bus.load_vec;
          state_d   = StScan;
`ifdef BITMAP_SCAN_COUNT_EN
          remaining_d = load_cnt;
`endif
        end else begin
          done_d = 1'b1;
        end
      end
    end else if (bus.flush || (hs && last)) begin
      // Flush wins over a concurrent handshake; either way the bitmap is finished.
      pending_d = '0;
      state_d   = StIdle;
      done_d    = 1'b1;
`ifdef BITMAP_SCAN_COUNT_EN
      remaining_d = '0;
`endif
    end else if (hs) begin
      pending_d = pending_q & ~lowest;
`ifdef BITMAP_SCAN_COUNT_EN
      remaining_d = remaining_q - CNT_W'(1);
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      pending_q <= '0;
      done_q    <= 1'b0;
`ifdef BITMAP_SCAN_COUNT_EN
      remaining_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      done_q    <= done_d;
`ifdef BITMAP_SCAN_COUNT_EN
      remaining_q <= remaining_d;
`endif
    end
  end

  assign bus.load_ready = load_ready;
  assign bus.idx_valid  = scan;
  assign bus.idx_out    = idx;
  assign bus.idx_last   = scan && last;
  assign bus.busy       = scan;
  assign bus.done       = done_q;

endmodule
